// File: rtl/one_op_exec_ctrl_if.sv
// Instruction-issue and write-back handshake bundle for the one-operand sequencer.
// The master issues decoded instructions and accepts write-backs; the slave is the controller.
interface one_op_exec_ctrl_if #(
   parameter int DATA_W = 16,
   parameter int REG_AW = 3
);
   logic              in_valid;
   logic              in_ready;
   logic [2:0]        in_opcode;
   logic [REG_AW-1:0] in_rd;
   logic [DATA_W-1:0] in_rds;
   logic              wb_valid;
   logic              wb_ready;
   logic              wb_we;
   logic [REG_AW-1:0] wb_rd;
   logic [DATA_W-1:0] wb_data;

   modport master (
      output in_valid, in_opcode, in_rd, in_rds, wb_ready,
      input  in_ready, wb_valid, wb_we, wb_rd, wb_data
   );

   modport slave (
      input  in_valid, in_opcode, in_rd, in_rds, wb_ready,
      output in_ready, wb_valid, wb_we, wb_rd, wb_data
   );
endinterface

// File: rtl/one_op_exec_ctrl.sv
// Sequencer for the shared-bus one-operand units: one instruction per handshake,
// one unit enable for one cycle, then a held write-back that commits CCR/out_port/count.
//
// state | meaning
// IDLE  | in_ready high, waiting for an instruction
// EXEC  | one unit enabled, result/flag buses captured at end of cycle
// WB    | write-back offered until wb_ready or flush
module one_op_exec_ctrl #(
   parameter int DATA_W = 16,
   parameter int REG_AW = 3,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   one_op_exec_ctrl_if.slave bus,
   input  logic              flush,
   output logic [6:0]        unit_en,
   output logic [DATA_W-1:0] unit_rds,
   output logic [2:0]        unit_prev_flags,
   input  logic [DATA_W-1:0] unit_result,
   input  logic [2:0]        unit_ccr,
   output logic [2:0]        ccr,
   output logic [DATA_W-1:0] out_port,
   output logic              out_strobe,
   output logic [CNT_W-1:0]  retire_count
);

   typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

   localparam logic [2:0] OP_NOP  = 3'd0;
   localparam logic [2:0] OP_SETC = 3'd1;
   localparam logic [2:0] OP_CLRC = 3'd2;
   localparam logic [2:0] OP_NOT  = 3'd3;
   localparam logic [2:0] OP_INC  = 3'd4;
   localparam logic [2:0] OP_DEC  = 3'd5;
   localparam logic [2:0] OP_OUT  = 3'd6;
   localparam logic [2:0] OP_IN   = 3'd7;

   state_t            state_q, state_d;
   logic              in_ready_q, in_ready_d;
   logic [6:0]        unit_en_q, unit_en_d;
   logic [2:0]        op_q, op_d;
   logic [REG_AW-1:0] rd_q, rd_d;
   logic [DATA_W-1:0] rds_q, rds_d;
   logic              wb_valid_q, wb_valid_d;
   logic              wb_we_q, wb_we_d;
   logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
   logic [DATA_W-1:0] wb_data_q, wb_data_d;
   logic [2:0]        pend_q, pend_d;
   logic [2:0]        ccr_q, ccr_d;
   logic [DATA_W-1:0] out_port_q, out_port_d;
   logic              out_strobe_q, out_strobe_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   function automatic logic [6:0] decode_en(input logic [2:0] op);
      case (op)
         OP_NOT:  decode_en = 7'b0000001;
         OP_INC:  decode_en = 7'b0000010;
         OP_DEC:  decode_en = 7'b0000100;
         OP_SETC: decode_en = 7'b0001000;
         OP_CLRC: decode_en = 7'b0010000;
         OP_OUT:  decode_en = 7'b0100000;
         OP_IN:   decode_en = 7'b1000000;
         default: decode_en = 7'b0000000;
      endcase
   endfunction

   // Units that actually drive the result bus; the rest write back the operand.
   function automatic logic uses_result(input logic [2:0] op);
      uses_result = (op == OP_NOT) || (op == OP_INC) || (op == OP_DEC) || (op == OP_IN);
   endfunction

   function automatic logic uses_flags(input logic [2:0] op);
      uses_flags = (op == OP_SETC) || (op == OP_CLRC) || (op == OP_NOT) ||
                   (op == OP_INC)  || (op == OP_DEC);
   endfunction

   always_comb begin
      state_d      = state_q;
      in_ready_d   = in_ready_q;
      unit_en_d    = 7'b0;
      op_d         = op_q;
      rd_d         = rd_q;
      rds_d        = rds_q;
      wb_valid_d   = wb_valid_q;
      wb_we_d      = wb_we_q;
      wb_rd_d      = wb_rd_q;
      wb_data_d    = wb_data_q;
      pend_d       = pend_q;
      ccr_d        = ccr_q;
      out_port_d   = out_port_q;
      out_strobe_d = 1'b0;
      cnt_d        = cnt_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid && !flush) begin
               op_d       = bus.in_opcode;
               rd_d       = bus.in_rd;
               rds_d      = bus.in_rds;
               unit_en_d  = decode_en(bus.in_opcode);
               in_ready_d = 1'b0;
               state_d    = EXEC;
            end
         end
         EXEC: begin
            if (flush) begin
               in_ready_d = 1'b1;
               state_d    = IDLE;
            end else begin
               wb_data_d  = uses_result(op_q) ? unit_result : rds_q;
               pend_d     = uses_flags(op_q) ? unit_ccr : ccr_q;
               wb_we_d    = uses_result(op_q);
               wb_rd_d    = rd_q;
               wb_valid_d = 1'b1;
               state_d    = WB;
            end
         end
         WB: begin
            // flush outranks wb_ready: nothing commits
            if (flush) begin
               wb_valid_d = 1'b0;
               in_ready_d = 1'b1;
               state_d    = IDLE;
            end else if (bus.wb_ready) begin
               ccr_d = pend_q;
               if (op_q == OP_OUT) begin
                  out_port_d   = rds_q;
                  out_strobe_d = 1'b1;
               end
               cnt_d      = cnt_q + CNT_W'(1);
               wb_valid_d = 1'b0;
               in_ready_d = 1'b1;
               state_d    = IDLE;
            end
         end
         default: begin
            wb_valid_d = 1'b0;
            in_ready_d = 1'b1;
            state_d    = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         in_ready_q   <= 1'b1;
         unit_en_q    <= 7'b0;
         op_q         <= 3'b0;
         rd_q         <= '0;
         rds_q        <= '0;
         wb_valid_q   <= 1'b0;
         wb_we_q      <= 1'b0;
         wb_rd_q      <= '0;
         wb_data_q    <= '0;
         pend_q       <= 3'b0;
         ccr_q        <= 3'b0;
         out_port_q   <= '0;
         out_strobe_q <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         in_ready_q   <= in_ready_d;
         unit_en_q    <= unit_en_d;
         op_q         <= op_d;
         rd_q         <= rd_d;
         rds_q        <= rds_d;
         wb_valid_q   <= wb_valid_d;
         wb_we_q      <= wb_we_d;
         wb_rd_q      <= wb_rd_d;
         wb_data_q    <= wb_data_d;
         pend_q       <= pend_d;
         ccr_q        <= ccr_d;
         out_port_q   <= out_port_d;
         out_strobe_q <= out_strobe_d;
         cnt_q        <= cnt_d;
      end
   end

   assign bus.in_ready    = in_ready_q;
   assign bus.wb_valid    = wb_valid_q;
   assign bus.wb_we       = wb_we_q;
   assign bus.wb_rd       = wb_rd_q;
   assign bus.wb_data     = wb_data_q;
   assign unit_en         = unit_en_q;
   assign unit_rds        = rds_q;
   assign unit_prev_flags = ccr_q;
   assign ccr             = ccr_q;
   assign out_port        = out_port_q;
   assign out_strobe      = out_strobe_q;
   assign retire_count    = cnt_q;

endmodule

// File: tb/tb_one_op_exec_ctrl.sv
// Scoreboard bench for one_op_exec_ctrl: behavioural units on the shared buses,
// directed instructions with hand-computed write-backs and commits.
module tb_one_op_exec_ctrl;
   localparam int DATA_W = 16;
   localparam int REG_AW = 3;
   localparam int CNT_W  = 5;

   logic              clk;
   logic              rst_n;
   logic              flush;
   logic [6:0]        unit_en;
   logic [DATA_W-1:0] unit_rds;
   logic [2:0]        unit_prev_flags;
   logic [DATA_W-1:0] u_res;
   logic [2:0]        u_ccr;
   logic [2:0]        ccr;
   logic [DATA_W-1:0] out_port;
   logic              out_strobe;
   logic [CNT_W-1:0]  retire_count;
   logic [16:0]       t17;
   logic              ovr_on;
   logic [2:0]        ovr_flags;

   one_op_exec_ctrl_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();

   one_op_exec_ctrl #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .flush(flush),
      .unit_en(unit_en), .unit_rds(unit_rds), .unit_prev_flags(unit_prev_flags),
      .unit_result(u_res), .unit_ccr(u_ccr), .ccr(ccr), .out_port(out_port),
      .out_strobe(out_strobe), .retire_count(retire_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural units; undriven bus reads as DEAD / 010 so wrong captures show.
   always_comb begin
      t17   = 17'd0;
      u_res = 16'hDEAD;
      u_ccr = 3'b010;
      case (unit_en)
         7'b0000001: begin
            u_res = ~unit_rds;
            u_ccr = {unit_prev_flags[2], u_res[15], (u_res == 16'h0)};
         end
         7'b0000010: begin
            t17   = {1'b0, unit_rds} + 17'd1;
            u_res = t17[15:0];
            u_ccr = {t17[16], t17[15], (t17[15:0] == 16'h0)};
         end
         7'b0000100: begin
            t17   = {1'b0, unit_rds} - 17'd1;
            u_res = t17[15:0];
            u_ccr = {t17[16], t17[15], (t17[15:0] == 16'h0)};
         end
         7'b0001000: u_ccr = unit_prev_flags | 3'b100;
         7'b0010000: u_ccr = unit_prev_flags & 3'b011;
         7'b1000000: begin
            u_res = unit_rds;
            u_ccr = ~unit_prev_flags;
         end
         default: ;
      endcase
      if (ovr_on && (unit_en != 7'b0)) u_ccr = ovr_flags;
   end

   typedef struct {
      logic              we;
      logic [REG_AW-1:0] rd;
      logic [DATA_W-1:0] data;
      logic [2:0]        ccr;
      logic [CNT_W-1:0]  cnt;
      logic              is_out;
      logic [DATA_W-1:0] outp;
   } exp_t;

   exp_t             sb[$];
   int               total = 0;
   int               bad   = 0;
   logic [CNT_W-1:0] cnt_m = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compare write-back on handshake, then commits one cycle later.
   initial begin
      bit   post;
      exp_t e;
      post = 1'b0;
      forever begin
         @(negedge clk);
         if (post) begin
            e = sb.pop_front();
            chk("ccr_commit", 32'(ccr), 32'(e.ccr));
            chk("retire_count", 32'(retire_count), 32'(e.cnt));
            chk("out_strobe", 32'(out_strobe), 32'(e.is_out));
            if (e.is_out) chk("out_port", 32'(out_port), 32'(e.outp));
            post = 1'b0;
         end else if (rst_n && bus.wb_valid && bus.wb_ready && !flush) begin
            if (sb.size() == 0) begin
               chk("unexpected_wb", 32'(bus.wb_valid), 32'd0);
            end else begin
               e = sb[0];
               chk("wb_we", 32'(bus.wb_we), 32'(e.we));
               chk("wb_rd", 32'(bus.wb_rd), 32'(e.rd));
               chk("wb_data", 32'(bus.wb_data), 32'(e.data));
               post = 1'b1;
            end
         end
      end
   end

   task automatic wait_ready();
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
   endtask

   task automatic drive(input logic [2:0] op, input logic [REG_AW-1:0] rd, input logic [DATA_W-1:0] rds);
      wait_ready();
      @(posedge clk); #1;
      bus.in_valid  = 1'b1;
      bus.in_opcode = op;
      bus.in_rd     = rd;
      bus.in_rds    = rds;
      @(posedge clk); #1;
      bus.in_valid  = 1'b0;
   endtask

   task automatic issue(input logic [2:0] op, input logic [REG_AW-1:0] rd, input logic [DATA_W-1:0] rds,
                        input logic [6:0] en, input logic we, input logic [DATA_W-1:0] data,
                        input logic [2:0] ccr_after, input bit wait_done);
      exp_t e;
      int   n;
      cnt_m    = cnt_m + CNT_W'(1);
      e.we     = we;
      e.rd     = rd;
      e.data   = data;
      e.ccr    = ccr_after;
      e.cnt    = cnt_m;
      e.is_out = (op == 3'd6);
      e.outp   = rds;
      sb.push_back(e);
      drive(op, rd, rds);
      @(negedge clk);
      chk("exec_unit_en", 32'(unit_en), 32'(en));
      chk("exec_in_ready", 32'(bus.in_ready), 32'd0);
      chk("exec_wb_valid", 32'(bus.wb_valid), 32'd0);
      @(negedge clk);
      chk("wb_unit_en", 32'(unit_en), 32'd0);
      chk("wb_valid_lat", 32'(bus.wb_valid), 32'd1);
      if (wait_done) begin
         n = 0;
         while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
         end
         chk("retire_timeout", 32'(sb.size()), 32'd0);
      end
   endtask

   initial begin
      rst_n         = 1'b0;
      flush         = 1'b0;
      ovr_on        = 1'b0;
      ovr_flags     = 3'b000;
      bus.in_valid  = 1'b0;
      bus.in_opcode = 3'd0;
      bus.in_rd     = '0;
      bus.in_rds    = '0;
      bus.wb_ready  = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_unit_en", 32'(unit_en), 32'd0);
      chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
      chk("rst_wb_we", 32'(bus.wb_we), 32'd0);
      chk("rst_wb_rd", 32'(bus.wb_rd), 32'd0);
      chk("rst_wb_data", 32'(bus.wb_data), 32'd0);
      chk("rst_ccr", 32'(ccr), 32'd0);
      chk("rst_out_port", 32'(out_port), 32'd0);
      chk("rst_out_strobe", 32'(out_strobe), 32'd0);
      chk("rst_retire", 32'(retire_count), 32'd0);
      rst_n = 1'b1;

      //    op    rd    rds       unit_en      we    data      ccr
      issue(3'd1, 3'd1, 16'h0AAA, 7'b0001000, 1'b0, 16'h0AAA, 3'b100, 1'b1);
      issue(3'd4, 3'd2, 16'hFFFF, 7'b0000010, 1'b1, 16'h0000, 3'b101, 1'b1);
      ovr_on = 1'b1; ovr_flags = 3'b011;
      issue(3'd4, 3'd3, 16'h0005, 7'b0000010, 1'b1, 16'h0006, 3'b011, 1'b1);
      ovr_on = 1'b0;
      issue(3'd1, 3'd1, 16'h5555, 7'b0001000, 1'b0, 16'h5555, 3'b111, 1'b1);
      issue(3'd2, 3'd2, 16'hAAAA, 7'b0010000, 1'b0, 16'hAAAA, 3'b011, 1'b1);
      issue(3'd6, 3'd4, 16'h1234, 7'b0100000, 1'b0, 16'h1234, 3'b011, 1'b1);
      @(negedge clk);
      chk("out_strobe_drop", 32'(out_strobe), 32'd0);
      chk("out_port_hold", 32'(out_port), 32'h1234);
      issue(3'd7, 3'd5, 16'hBEEF, 7'b1000000, 1'b1, 16'hBEEF, 3'b011, 1'b1);
      issue(3'd0, 3'd6, 16'h7777, 7'b0000000, 1'b0, 16'h7777, 3'b011, 1'b1);

      // NOT with write-back stalled for 5 cycles
      @(posedge clk); #1 bus.wb_ready = 1'b0;
      issue(3'd3, 3'd7, 16'h00FF, 7'b0000001, 1'b1, 16'hFF00, 3'b010, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_wb_valid", 32'(bus.wb_valid), 32'd1);
         chk("stall_wb_data", 32'(bus.wb_data), 32'hFF00);
         chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
         chk("stall_ccr", 32'(ccr), 32'b011);
      end
      @(posedge clk); #1 bus.wb_ready = 1'b1;
      for (int n = 0; n < 40 && sb.size() != 0; n++) @(negedge clk);
      chk("stall_retired", 32'(sb.size()), 32'd0);

      // DEC flushed in WB: nothing commits
      @(posedge clk); #1 bus.wb_ready = 1'b0;
      drive(3'd5, 3'd3, 16'h0001);
      @(negedge clk);
      chk("dec_unit_en", 32'(unit_en), 32'b0000100);
      @(posedge clk); #1;
      flush = 1'b1; bus.wb_ready = 1'b1;
      @(negedge clk);
      chk("dec_wb_data", 32'(bus.wb_data), 32'h0000);
      @(posedge clk); #1 flush = 1'b0;
      @(negedge clk);
      chk("flush_wb_valid", 32'(bus.wb_valid), 32'd0);
      chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
      chk("flush_ccr", 32'(ccr), 32'b010);
      chk("flush_retire", 32'(retire_count), 32'(cnt_m));

      // flush in IDLE blocks acceptance
      @(posedge clk); #1;
      flush = 1'b1; bus.in_valid = 1'b1; bus.in_opcode = 3'd4;
      @(posedge clk); #1;
      flush = 1'b0; bus.in_valid = 1'b0;
      @(negedge clk);
      chk("idle_flush_unit_en", 32'(unit_en), 32'd0);
      chk("idle_flush_in_ready", 32'(bus.in_ready), 32'd1);

      // counter wraps from all-ones to zero
      while (cnt_m != '1)
         issue(3'd0, 3'd0, 16'h0101, 7'b0, 1'b0, 16'h0101, 3'b010, 1'b1);
      issue(3'd0, 3'd1, 16'h0202, 7'b0, 1'b0, 16'h0202, 3'b010, 1'b1);
      chk("retire_wrap", 32'(retire_count), 32'd0);

      // reset in the middle of EXEC with ccr=101
      issue(3'd4, 3'd2, 16'hFFFF, 7'b0000010, 1'b1, 16'h0000, 3'b101, 1'b1);
      drive(3'd4, 3'd4, 16'h0010);
      @(negedge clk);
      chk("pre_rst_unit_en", 32'(unit_en), 32'b0000010);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_unit_en", 32'(unit_en), 32'd0);
      chk("mid_rst_ccr", 32'(ccr), 32'd0);
      chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("mid_rst_wb_valid", 32'(bus.wb_valid), 32'd0);
      chk("mid_rst_wb_data", 32'(bus.wb_data), 32'd0);
      chk("mid_rst_out_port", 32'(out_port), 32'd0);
      chk("mid_rst_retire", 32'(retire_count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("post_rst_ccr", 32'(ccr), 32'd0);
      chk("post_rst_retire", 32'(retire_count), 32'd0);
      chk("post_rst_wb_valid", 32'(bus.wb_valid), 32'd0);
      chk("post_rst_unit_en", 32'(unit_en), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
